// File: rtl/app_echo_pkg.sv
// Shared constants for the app_echo byte responder:
// ASCII codes, FSM state encodings and the case-fold helper.
package app_echo_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_LF   = 2'd2;

  function automatic logic [7:0] to_upper(
    input logic [7:0] b
  );
    if (b >= ASCII_LC_A && b <= ASCII_LC_Z)
      return b - 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/app_fifo.sv
// Byte FIFO, show-ahead read. Ports: clk_i, rstn_i,
// push_i/data_i write, pop_i/data_o read, full_o, empty_o.
module app_fifo
  import app_echo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_o = (wr_ptr == rd_ptr);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i)
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= data_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/app_echo.sv
// Echo host bytes back upper-cased, CR->CRLF optional.
// Ports: out_* from host, in_* to host, sleep_o on idle.
module app_echo
  import app_echo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int IDLE_CYCLES = 2000000,
  parameter int CRLF_EXPAND = 1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       sleep_o
);

  localparam int CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);

  logic [1:0]    st;
  logic          rdy_q;
  logic [CW-1:0] idle_cnt;
  logic [7:0]    fifo_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          xfer;
  logic          lf_next;
  logic          go_idle;
  logic          idle;

  // rdy_q keeps out_ready_o low through reset
  assign out_ready_o = rdy_q & ~full;
  assign push = out_valid_i & out_ready_o;
  assign xfer = in_valid_o & in_ready_i;

  assign lf_next = xfer && (st == ST_SEND) &&
                   (in_data_o == ASCII_CR) &&
                   (CRLF_EXPAND != 0);
  assign pop = ~empty &
               ((st == ST_IDLE) | (xfer & ~lf_next));
  assign go_idle = xfer & ~lf_next & empty;

  assign idle = empty & (st == ST_IDLE) & ~out_valid_i;

  app_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .data_i  (out_data_i),
    .pop_i   (pop),
    .data_o  (fifo_q),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st         <= ST_IDLE;
      in_valid_o <= 1'b0;
      in_data_o  <= 8'h00;
    end else begin
      unique case (1'b1)
        lf_next: begin
          in_data_o <= ASCII_LF;
          st        <= ST_LF;
        end
        pop: begin
          in_data_o  <= to_upper(fifo_q);
          in_valid_o <= 1'b1;
          st         <= ST_SEND;
        end
        go_idle: begin
          in_valid_o <= 1'b0;
          st         <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // sleep is gated by idle so it drops one edge
  // after traffic resumes
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idle_cnt <= '0;
      sleep_o  <= 1'b0;
    end else begin
      sleep_o <= idle & (idle_cnt == IDLE_MAX);
      if (!idle)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_app_echo.sv
// Directed + random bench for app_echo with a
// queue-based reference of the echoed stream.
module tb_app_echo;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       sleep;

  logic [7:0] d0;
  logic       v0;
  logic       rdy0;
  logic [7:0] in_data0;
  logic       in_valid0;
  logic       sleep0;
  logic       in_ready0 = 1'b1;

  int checks = 0;
  int passes = 0;
  int n_acc  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  logic [7:0] log0_q[$];

  logic       stall_q = 1'b0;
  logic [7:0] held_q;

  always #5 clk = ~clk;

  app_echo #(
    .DEPTH(16), .IDLE_CYCLES(20), .CRLF_EXPAND(1)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .out_data_i(out_data), .out_valid_i(out_valid),
    .out_ready_o(out_ready),
    .in_data_o(in_data), .in_valid_o(in_valid),
    .in_ready_i(in_ready), .sleep_o(sleep)
  );

  app_echo #(
    .DEPTH(16), .IDLE_CYCLES(20), .CRLF_EXPAND(0)
  ) dut0 (
    .clk_i(clk), .rstn_i(rstn),
    .out_data_i(d0), .out_valid_i(v0),
    .out_ready_o(rdy0),
    .in_data_o(in_data0), .in_valid_o(in_valid0),
    .in_ready_i(in_ready0), .sleep_o(sleep0)
  );

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s obs=%0h exp=%0h",
                tag, obs, expv);
  endtask

  function automatic logic [7:0] up(logic [7:0] b);
    if (b >= "a" && b <= "z") return b - 8'd32;
    return b;
  endfunction

  // mid-cycle sampling predicts next-edge transfers
  always @(negedge clk) begin
    if (rstn) begin
      if (stall_q)
        chk("hold", {in_valid, in_data},
            {1'b1, held_q});
      if (out_valid && out_ready) begin
        n_acc++;
        exp_q.push_back(up(out_data));
        if (out_data == 8'h0D)
          exp_q.push_back(8'h0A);
      end
      if (in_valid && in_ready) begin
        log_q.push_back(in_data);
        chk("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("stream", in_data, exp_q.pop_front());
      end
      if (in_valid0 && in_ready0)
        log0_q.push_back(in_data0);
      stall_q = in_valid & ~in_ready;
      held_q  = in_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string tag);
    int n = 0;
    in_ready = 1'b1;
    while ((exp_q.size() != 0 || in_valid) && n < 500) begin
      step();
      n++;
    end
    chk(tag, (exp_q.size() == 0) && !in_valid, 1);
  endtask

  task automatic send(logic [7:0] b);
    int n = 0;
    out_valid = 1'b1;
    out_data  = b;
    @(negedge clk);
    while (!out_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_tmo", out_ready, 1);
    step();
    out_valid = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] held;
    logic [7:0] r;

    rstn = 1'b0;
    out_valid = 1'b0; out_data = 8'h00;
    in_ready = 1'b1;
    v0 = 1'b0; d0 = 8'h00;

    // 1: reset values, ready, sleep timing
    repeat (3) step();
    chk("rst_ordy", out_ready, 0);
    chk("rst_ival", in_valid, 0);
    chk("rst_idat", in_data, 8'h00);
    chk("rst_sleep", sleep, 0);
    rstn = 1'b1;
    step();
    chk("e1_ordy", out_ready, 1);
    chk("e1_ival", in_valid, 0);
    repeat (19) step();
    chk("sleep_e20", sleep, 0);
    step();
    chk("sleep_e21", sleep, 1);
    out_valid = 1'b1; out_data = "x";
    step();
    chk("sleep_drop", sleep, 0);
    out_valid = 1'b0;
    drain("drain1");

    // 2: "ab1Z" back to back
    step();
    out_valid = 1'b1; out_data = "a";
    step();
    chk("ab_lat0", in_valid, 0);
    out_data = "b";
    step();
    chk("ab_0", {in_valid, in_data}, {1'b1, 8'h41});
    out_data = "1";
    step();
    chk("ab_1", {in_valid, in_data}, {1'b1, 8'h42});
    out_data = "Z";
    step();
    chk("ab_2", {in_valid, in_data}, {1'b1, 8'h31});
    out_valid = 1'b0;
    step();
    chk("ab_3", {in_valid, in_data}, {1'b1, 8'h5A});
    step();
    chk("ab_end", in_valid, 0);
    drain("drain2");

    // 3: CR expansion on and off
    log_q.delete();
    log0_q.delete();
    out_valid = 1'b1; out_data = 8'h0D;
    v0 = 1'b1; d0 = 8'h0D;
    step();
    out_data = 8'h78; d0 = 8'h78;
    step();
    out_valid = 1'b0; v0 = 1'b0;
    repeat (8) step();
    chk("crlf_n", log_q.size(), 3);
    chk("crlf_0", log_q[0], 8'h0D);
    chk("crlf_1", log_q[1], 8'h0A);
    chk("crlf_2", log_q[2], 8'h58);
    chk("nocr_n", log0_q.size(), 2);
    chk("nocr_0", log0_q[0], 8'h0D);
    chk("nocr_1", log0_q[1], 8'h58);
    drain("drain3");

    // 4: fill with sink stalled
    in_ready = 1'b0;
    base = n_acc;
    out_valid = 1'b1;
    out_data = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      step();
      if (!out_ready) break;
      out_data = 8'($urandom);
    end
    out_valid = 1'b0;
    chk("fill_cnt", n_acc - base, 17);
    chk("fill_ordy", out_ready, 0);
    held = in_data;
    repeat (3) step();
    chk("fill_hold", {in_valid, in_data}, {1'b1, held});
    drain("drain4");

    // 5: random traffic with random stalls
    base = n_acc;
    n = 0;
    while (n_acc - base < 1000 && n < 20000) begin
      out_valid = ($urandom_range(0, 3) != 0);
      r = 8'($urandom_range(0, 7));
      if (r == 0) out_data = 8'h0D;
      else if (r < 3) out_data = 8'($urandom_range(8'h61, 8'h7A));
      else out_data = 8'($urandom);
      in_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    out_valid = 1'b0;
    chk("rand_cnt", n_acc - base, 1000);
    drain("drain5");

    // 6: reset while in LF state with bytes queued
    in_ready = 1'b0;
    out_valid = 1'b1; out_data = 8'h0D;
    step();
    for (int i = 0; i < 8; i++) begin
      out_data = 8'($urandom_range(8'h61, 8'h7A));
      step();
    end
    out_valid = 1'b0;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    chk("lf_state", {in_valid, in_data}, {1'b1, 8'h0A});
    rstn = 1'b0;
    #1;
    chk("ar_ordy", out_ready, 0);
    chk("ar_ival", in_valid, 0);
    chk("ar_idat", in_data, 8'h00);
    chk("ar_sleep", sleep, 0);
    exp_q.delete();
    repeat (2) step();
    rstn = 1'b1;
    log_q.delete();
    in_ready = 1'b1;
    repeat (10) step();
    chk("post_rst_n", log_q.size(), 0);
    chk("post_rst_v", in_valid, 0);
    send("q");
    drain("drain6");
    chk("post_rst_q", log_q[0], 8'h51);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
